// File: rtl/eth_rx_filter_pkg.sv
// Shared types and constants for the Ethernet receive MAC address filter.
// Holds the filter state encoding, header geometry and the address-match rule.
package eth_rx_filter_pkg;

  localparam int          HDR_LEN   = 6;
  localparam logic [2:0]  HDR_LAST  = 3'(HDR_LEN - 1);
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    HDR    = 2'd0,
    REPLAY = 2'd1,
    FWD    = 2'd2,
    DROP   = 2'd3
  } state_e;

  // Byte 0 of the DA lands in [47:40], so its group bit is da[40].
  function automatic logic addr_match(input logic [47:0] da,
                                      input logic [47:0] station,
                                      input logic        promisc,
                                      input logic        bcast_en,
                                      input logic        mcast_en);
    return promisc | (da == station) | (bcast_en & (da == MAC_BCAST)) | (mcast_en & da[40]);
  endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module eth_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Byte-wide AXIS receive filter: buffers the 6-byte DA, decides pass/drop, replays and forwards.
// Define ETH_RX_FILTER_STATS_EN to build the saturating pass/drop frame counters.
module eth_rx_mac_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic [47:0]          cfg_mac_addr,
  input  logic                 cfg_promisc,
  input  logic                 cfg_bcast_en,
  input  logic                 cfg_mcast_en,
  output logic                 stat_pass,
  output logic                 stat_drop,
  output logic                 stat_runt,
  output logic [CNT_WIDTH-1:0] stat_pass_count,
  output logic [CNT_WIDTH-1:0] stat_drop_count
);

  state_e     state_q, state_d;
  logic [2:0] hdr_cnt_q, hdr_cnt_d;
  logic       last_q, last_d;
  logic       user_q, user_d;
  logic       pass_q, pass_d;
  logic       drop_q, drop_d;
  logic       runt_q, runt_d;
  logic       buf_we;
  logic [7:0] hdr_buf_q [HDR_LEN];
  logic       s_accept, m_accept, hdr_match;

  assign s_accept  = s_axis_tvalid & s_axis_tready;
  assign m_accept  = m_axis_tvalid & m_axis_tready;
  assign hdr_match = addr_match({hdr_buf_q[0], hdr_buf_q[1], hdr_buf_q[2],
                                 hdr_buf_q[3], hdr_buf_q[4], s_axis_tdata},
                                cfg_mac_addr, cfg_promisc, cfg_bcast_en, cfg_mcast_en);

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_q   <= HDR;
      hdr_cnt_q <= '0;
      last_q    <= 1'b0;
      user_q    <= 1'b0;
      pass_q    <= 1'b0;
      drop_q    <= 1'b0;
      runt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      last_q    <= last_d;
      user_q    <= user_d;
      pass_q    <= pass_d;
      drop_q    <= drop_d;
      runt_q    <= runt_d;
    end
  end

  // NOTE: the header buffer is pure datapath storage and is deliberately left unreset;
  // every entry is rewritten before the REPLAY state can read it.
  always_ff @(posedge logic_clk) begin
    if (buf_we) begin
      hdr_buf_q[hdr_cnt_q] <= s_axis_tdata;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    last_d    = last_q;
    user_d    = user_q;
    pass_d    = 1'b0;
    drop_d    = 1'b0;
    runt_d    = 1'b0;
    buf_we    = 1'b0;
    case (state_q)
      HDR: begin
        if (s_accept) begin
          buf_we = 1'b1;
          if (hdr_cnt_q == HDR_LAST) begin
            hdr_cnt_d = '0;
            last_d    = s_axis_tlast;
            user_d    = s_axis_tuser;
            if (hdr_match) begin
              pass_d  = 1'b1;
              state_d = REPLAY;
            end else begin
              drop_d  = 1'b1;
              state_d = s_axis_tlast ? HDR : DROP;
            end
          end else if (s_axis_tlast) begin
            runt_d    = 1'b1;
            drop_d    = 1'b1;
            hdr_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end
      REPLAY: begin
        if (m_accept) begin
          if (hdr_cnt_q == HDR_LAST) begin
            hdr_cnt_d = '0;
            state_d   = last_q ? HDR : FWD;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end
      FWD, DROP: begin
        if (s_accept && s_axis_tlast) begin
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  // Outputs are forced idle while reset is asserted, independent of the register contents.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    if (!logic_rst) begin
      case (state_q)
        HDR, DROP: s_axis_tready = 1'b1;
        REPLAY: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = hdr_buf_q[hdr_cnt_q];
          m_axis_tlast  = (hdr_cnt_q == HDR_LAST) & last_q;
          m_axis_tuser  = (hdr_cnt_q == HDR_LAST) & user_q;
        end
        FWD: begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tlast  = s_axis_tlast;
          m_axis_tuser  = s_axis_tuser;
        end
        default: ;
      endcase
    end
  end

  assign stat_pass = pass_q & ~logic_rst;
  assign stat_drop = drop_q & ~logic_rst;
  assign stat_runt = runt_q & ~logic_rst;

`ifdef ETH_RX_FILTER_STATS_EN
  logic [CNT_WIDTH-1:0] pass_cnt, drop_cnt;

  eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
    .clk     (logic_clk),
    .clr_i   (logic_rst),
    .inc_i   (pass_q),
    .count_o (pass_cnt)
  );

  eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk     (logic_clk),
    .clr_i   (logic_rst),
    .inc_i   (drop_q),
    .count_o (drop_cnt)
  );

  assign stat_pass_count = logic_rst ? '0 : pass_cnt;
  assign stat_drop_count = logic_rst ? '0 : drop_cnt;
`else
  assign stat_pass_count = '0;
  assign stat_drop_count = '0;
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Self-checking bench for eth_rx_mac_filter: directed scenarios plus randomized frames
// scored against a frame-level reference model (address rules applied to whole frames).
module tb_eth_rx_mac_filter;

  localparam int CW = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic          clk, rst;
  logic [7:0]    s_tdata, m_tdata;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic [47:0]   cfg_mac;
  logic          cfg_promisc, cfg_bcast, cfg_mcast;
  logic          st_pass, st_drop, st_runt;
  logic [CW-1:0] pass_cnt, drop_cnt;

  eth_rx_mac_filter #(.CNT_WIDTH(CW)) dut (
    .logic_clk       (clk),
    .logic_rst       (rst),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .s_axis_tuser    (s_tuser),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .m_axis_tuser    (m_tuser),
    .cfg_mac_addr    (cfg_mac),
    .cfg_promisc     (cfg_promisc),
    .cfg_bcast_en    (cfg_bcast),
    .cfg_mcast_en    (cfg_mcast),
    .stat_pass       (st_pass),
    .stat_drop       (st_drop),
    .stat_runt       (st_runt),
    .stat_pass_count (pass_cnt),
    .stat_drop_count (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0, checks = 0;
  beat_t exp_q[$], got_q[$];
  int    exp_pass = 0, exp_drop = 0, exp_runt = 0;
  int    n_pass = 0, n_drop = 0, n_runt = 0, both_cnt = 0;
  int    cyc = 0, in_idx = 0, hdr6_cyc = -10, rise_cyc = -1;
  int    unstable_cnt = 0;
  bit    stall_en = 0, gap_en = 0;
  bit    prev_mvalid = 0, prev_stalled = 0, tready_low_seen = 0, mvalid_seen = 0;
  beat_t prev_beat;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_tready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Passive monitor: samples on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (rst) begin
      prev_mvalid  = 0;
      prev_stalled = 0;
      in_idx       = 0;
    end else begin
      if (s_tvalid && !s_tready) tready_low_seen = 1;
      if (m_tvalid) mvalid_seen = 1;
      if (s_tvalid && s_tready) begin
        if (in_idx == 5) hdr6_cyc = cyc;
        in_idx = s_tlast ? 0 : in_idx + 1;
      end
      if (m_tvalid && !prev_mvalid) rise_cyc = cyc;
      if (prev_stalled && (!m_tvalid || beat_t'({m_tdata, m_tlast, m_tuser}) != prev_beat))
        unstable_cnt++;
      if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tlast, m_tuser});
      prev_stalled = m_tvalid && !m_tready;
      prev_beat    = {m_tdata, m_tlast, m_tuser};
      prev_mvalid  = m_tvalid;
      if (st_pass) n_pass++;
      if (st_drop) n_drop++;
      if (st_runt) n_runt++;
      if (st_pass && st_drop) both_cnt++;
    end
  end

  function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef ETH_RX_FILTER_STATS_EN
    return (n >= (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(n);
`else
    return (n < 0) ? CW'(1) : '0;
`endif
  endfunction

  function automatic bit model_match(input bq_t f);
    logic [47:0] da;
    da = {f[0], f[1], f[2], f[3], f[4], f[5]};
    return cfg_promisc || (da == cfg_mac) || (cfg_bcast && da == 48'hFFFF_FFFF_FFFF)
           || (cfg_mcast && f[0][0]);
  endfunction

  function automatic bq_t build(input logic [47:0] da, input int len);
    bq_t f;
    for (int i = 0; i < len; i++)
      f.push_back(i < 6 ? da[47 - 8 * i -: 8] : 8'($urandom));
    return f;
  endfunction

  task automatic drive_byte(input logic [7:0] d, input logic l, input logic u);
    int budget;
    bit acc;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      s_tvalid = 0;
      @(posedge clk); #1;
    end
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1;
    budget = 1000; acc = 0;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      budget--;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL drive_timeout: byte %02h not accepted within 1000 cycles", d);
    end
    s_tvalid = 0;
  endtask

  task automatic send_frame(input bq_t f, input bit bad);
    int n = f.size();
    if (n < 6) begin
      exp_runt++; exp_drop++;
    end else if (model_match(f)) begin
      exp_pass++;
      for (int i = 0; i < n; i++) exp_q.push_back({f[i], i == n - 1, bad && i == n - 1});
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < n; i++) drive_byte(f[i], i == n - 1, bad && i == n - 1);
  endtask

  task automatic wait_idle(output bit timed_out);
    int budget = 3000;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (4) @(posedge clk);
    #1;
    timed_out = (got_q.size() < exp_q.size());
  endtask

  task automatic test_reset();
    rst = 1; s_tvalid = 1; s_tdata = 8'hA5; s_tlast = 1; s_tuser = 1;
    cfg_mac = 48'h02_00_00_00_00_01; cfg_promisc = 0; cfg_bcast = 0; cfg_mcast = 0;
    #1;
    checks++; if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin errors++;
      $display("FAIL reset_first_cycle: tready=%b tvalid=%b want 0 0", s_tready, m_tvalid); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b want 0", m_tvalid); end
    checks++; if ({m_tdata, m_tlast, m_tuser} !== 10'd0) begin errors++;
      $display("FAIL reset_mdata: got %h/%b/%b want 0", m_tdata, m_tlast, m_tuser); end
    checks++; if ({st_pass, st_drop, st_runt} !== 3'b000) begin errors++;
      $display("FAIL reset_stats: got %b want 000", {st_pass, st_drop, st_runt}); end
    checks++; if (pass_cnt !== '0 || drop_cnt !== '0) begin errors++;
      $display("FAIL reset_counts: got %0d %0d want 0 0", pass_cnt, drop_cnt); end
    s_tvalid = 0; s_tlast = 0; s_tuser = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin errors++;
      $display("FAIL post_reset_idle: tready=%b tvalid=%b want 1 0", s_tready, m_tvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_unicast_pass();
    bit to;
    rise_cyc = -1;
    send_frame(build(48'h02_00_00_00_00_01, 64), 0);
    wait_idle(to);
    checks++; if (to || got_q.size() != 64) begin errors++;
      $display("FAIL pass_len: got %0d beats want 64", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL pass_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (rise_cyc != hdr6_cyc + 1) begin errors++;
      $display("FAIL pass_latency: valid at cycle %0d want %0d", rise_cyc, hdr6_cyc + 1); end
    checks++; if (n_pass !== 1 || n_drop !== 0) begin errors++;
      $display("FAIL pass_pulses: pass=%0d drop=%0d want 1 0", n_pass, n_drop); end
    checks++; if (pass_cnt !== exp_cnt(exp_pass)) begin errors++;
      $display("FAIL pass_count: got %0d want %0d", pass_cnt, exp_cnt(exp_pass)); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_unicast_drop();
    bit to;
    mvalid_seen = 0; tready_low_seen = 0;
    send_frame(build(48'h02_00_00_00_00_02, 40), 0);
    wait_idle(to);
    checks++; if (mvalid_seen || got_q.size() != 0) begin errors++;
      $display("FAIL drop_output: got %0d beats valid_seen=%b want 0 0", got_q.size(), mvalid_seen); end
    checks++; if (tready_low_seen) begin errors++; $display("FAIL drop_tready: got low want always 1"); end
    checks++; if (n_drop !== exp_drop || n_pass !== exp_pass) begin errors++;
      $display("FAIL drop_pulses: drop=%0d pass=%0d want %0d %0d", n_drop, n_pass, exp_drop, exp_pass); end
    checks++; if (drop_cnt !== exp_cnt(exp_drop)) begin errors++;
      $display("FAIL drop_count: got %0d want %0d", drop_cnt, exp_cnt(exp_drop)); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_bcast();
    bit to;
    for (int en = 0; en < 2; en++) begin
      cfg_bcast = 1'(en);
      send_frame(build(48'hFFFF_FFFF_FFFF, 20), 0);
      wait_idle(to);
      checks++; if (to || got_q.size() != exp_q.size()) begin errors++;
        $display("FAIL bcast_len(en=%0d): got %0d want %0d", en, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++;
          $display("FAIL bcast_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (n_pass !== exp_pass || n_drop !== exp_drop) begin errors++;
        $display("FAIL bcast_pulses(en=%0d): pass=%0d drop=%0d want %0d %0d",
                 en, n_pass, n_drop, exp_pass, exp_drop); end
      exp_q.delete(); got_q.delete();
    end
    cfg_bcast = 0;
  endtask

  task automatic test_runt();
    bit to;
    mvalid_seen = 0;
    send_frame(build(48'h02_00_00_00_00_01, 4), 0);
    wait_idle(to);
    checks++; if (mvalid_seen) begin errors++; $display("FAIL runt_output: got valid want none"); end
    checks++; if (n_runt !== 1 || n_drop !== exp_drop) begin errors++;
      $display("FAIL runt_pulses: runt=%0d drop=%0d want 1 %0d", n_runt, n_drop, exp_drop); end
    send_frame(build(48'h02_00_00_00_00_01, 12), 0);
    wait_idle(to);
    checks++; if (to || got_q.size() != 12) begin errors++;
      $display("FAIL runt_next_len: got %0d want 12", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL runt_next_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_six_byte_stall();
    bit to;
    stall_en = 1; unstable_cnt = 0;
    for (int k = 0; k < 3; k++) send_frame(build(48'h02_00_00_00_00_01, 6), 1);
    wait_idle(to);
    stall_en = 0;
    checks++; if (to || got_q.size() != 18) begin errors++;
      $display("FAIL six_len: got %0d want 18", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL six_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (unstable_cnt != 0) begin errors++;
      $display("FAIL six_stable: got %0d changes during stall want 0", unstable_cnt); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    bit to;
    gap_en = 0;
    send_frame(build(48'h02_00_00_00_00_01, 9), 0);
    send_frame(build(48'h02_00_00_00_00_01, 3), 0);
    send_frame(build(48'h02_00_00_00_00_09, 7), 0);
    send_frame(build(48'h02_00_00_00_00_01, 6), 0);
    send_frame(build(48'h02_00_00_00_00_01, 10), 1);
    wait_idle(to);
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL b2b_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL b2b_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (n_pass !== exp_pass || n_drop !== exp_drop || n_runt !== exp_runt) begin errors++;
      $display("FAIL b2b_pulses: %0d/%0d/%0d want %0d/%0d/%0d",
               n_pass, n_drop, n_runt, exp_pass, exp_drop, exp_runt); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    bit to;
    logic [47:0] da;
    stall_en = 1; gap_en = 1; unstable_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cfg_mac     = {16'h0200, 32'($urandom)};
      cfg_promisc = ($urandom_range(0, 7) == 0);
      cfg_bcast   = 1'($urandom);
      cfg_mcast   = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       da = cfg_mac;
        1:       da = 48'hFFFF_FFFF_FFFF;
        2:       begin da = {16'($urandom), 32'($urandom)}; da[40] = 1'b1; end
        default: begin da = {16'($urandom), 32'($urandom)}; da[40] = 1'b0; end
      endcase
      send_frame(build(da, ($urandom_range(0, 4) == 0) ? 6 : $urandom_range(1, 30)), 1'($urandom));
    end
    wait_idle(to);
    stall_en = 0; gap_en = 0;
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL rand_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL rand_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (n_pass !== exp_pass || n_drop !== exp_drop || n_runt !== exp_runt) begin errors++;
      $display("FAIL rand_pulses: %0d/%0d/%0d want %0d/%0d/%0d",
               n_pass, n_drop, n_runt, exp_pass, exp_drop, exp_runt); end
    checks++; if (both_cnt != 0 || unstable_cnt != 0) begin errors++;
      $display("FAIL rand_protocol: both=%0d unstable=%0d want 0 0", both_cnt, unstable_cnt); end
    checks++; if (pass_cnt !== exp_cnt(exp_pass) || drop_cnt !== exp_cnt(exp_drop)) begin errors++;
      $display("FAIL rand_counts: got %0d %0d want %0d %0d",
               pass_cnt, drop_cnt, exp_cnt(exp_pass), exp_cnt(exp_drop)); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    m_tready = 1;
    test_reset();
    test_unicast_pass();
    test_unicast_drop();
    test_bcast();
    test_runt();
    test_six_byte_stall();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
